// File: rtl/saph_fpu_pkg.sv
// Shared FPU types: operand format, operation modes and the supported-mode mask.
// Also holds small sizing helpers used by the arbiter and its tag FIFO.
package saph_fpu_pkg;

    typedef logic [31:0] float;

    typedef enum logic [2:0] {
        FPU_ADD  = 3'd0,
        FPU_SUB  = 3'd1,
        FPU_MUL  = 3'd2,
        FPU_DIV  = 3'd3,
        FPU_SQRT = 3'd4,
        FPU_MIN  = 3'd5,
        FPU_MAX  = 3'd6,
        FPU_CVT  = 3'd7
    } fpu_mode_t;

    localparam int unsigned FPU_MODE_COUNT = 8;

    // One bit per fpu_mode_t value; bit m set means the FPU implements mode m.
    typedef logic [FPU_MODE_COUNT-1:0] fpu_modes_t;

    localparam float FLOAT_ZERO = 32'h0000_0000;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic mode_supported(input fpu_modes_t has, input fpu_mode_t m);
        return has[m];
    endfunction

endpackage

// File: rtl/saph_tag_fifo.sv
// Small synchronous FIFO holding requester tags for in-flight FPU operations.
// Pointers wrap modulo depth, so depth need not be a power of two.
module saph_tag_fifo
    import saph_fpu_pkg::*;
#(
    parameter int unsigned width = 1,
    parameter int unsigned depth = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [width-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [width-1:0]             pop_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(depth+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = idx_width(depth);
    localparam int unsigned CNT_W = $clog2(depth + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    logic [width-1:0] mem_q [depth];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(depth));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; an entry is only read after count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/saph_fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between several requesters; the tag FIFO
// remembers who issued each operation so in-order results route back correctly.
module saph_fpu_arbiter
    import saph_fpu_pkg::*;
#(
    parameter int unsigned ports = 2,
    parameter int unsigned depth = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ports-1:0]        req_trig,
    input  fpu_mode_t [ports-1:0]   req_mode,
    input  float [ports-1:0]        req_lhs,
    input  float [ports-1:0]        req_rhs,
    output logic [ports-1:0]        req_ready,
    output logic [ports-1:0]        resp_valid,
    output float                    resp_res,
    input  logic                    fpu_d_ready,
    input  fpu_modes_t              fpu_has_modes,
    output logic                    fpu_d_trig,
    output fpu_mode_t               fpu_d_mode,
    output float                    fpu_d_lhs,
    output float                    fpu_d_rhs,
    input  logic                    fpu_q_trig,
    input  float                    fpu_q_res,
    output logic                    err_orphan
);

    localparam int unsigned TAG_W = idx_width(ports);
    localparam int unsigned CNT_W = $clog2(depth + 1);

    typedef logic [TAG_W-1:0] tag_t;

    tag_t             last_q, last_d;
    logic             err_orphan_q, err_orphan_d;

    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    tag_t             head_tag;

    logic             pop, space;
    logic [ports-1:0] eligible;
    logic             grant_any;
    tag_t             grant_idx;
    tag_t             cand;

    // A returning result frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop   = fpu_q_trig && !fifo_empty && !rst;
    assign space = !fifo_full || pop;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < ports; i++) begin
            eligible[i] = req_trig[i] && mode_supported(fpu_has_modes, req_mode[i])
                          && fpu_d_ready && space && !rst;
        end
    end

    // Scan starts just after the last winner, so each requester waits at most ports-1 grants.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_q;
        cand      = '0;
        for (int unsigned k = 1; k <= ports; k++) begin
            cand = tag_t'((32'(last_q) + k) % ports);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        fpu_d_trig = 1'b0;
        fpu_d_mode = FPU_ADD;
        fpu_d_lhs  = FLOAT_ZERO;
        fpu_d_rhs  = FLOAT_ZERO;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
            fpu_d_trig           = 1'b1;
            fpu_d_mode           = req_mode[grant_idx];
            fpu_d_lhs            = req_lhs[grant_idx];
            fpu_d_rhs            = req_rhs[grant_idx];
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_res   = FLOAT_ZERO;
        if (pop) begin
            resp_valid[head_tag] = 1'b1;
            resp_res             = fpu_q_res;
        end
    end

    always_comb begin
        last_d       = grant_any ? grant_idx : last_q;
        err_orphan_d = err_orphan_q || (fpu_q_trig && fifo_empty);
    end

    // Reset value of last makes requester 0 the first winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q       <= tag_t'(ports - 1);
            err_orphan_q <= 1'b0;
        end else begin
            last_q       <= last_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign err_orphan = err_orphan_q;

    saph_tag_fifo #(
        .width (TAG_W),
        .depth (depth)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (grant_any),
        .push_data_i (grant_idx),
        .pop_i       (pop),
        .pop_data_o  (head_tag),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(grant_any && (fifo_count == CNT_W'(depth)) && !pop));

endmodule

// File: tb/tb_saph_fpu_arbiter.sv
// Scoreboard bench for saph_fpu_arbiter: a queue-based reference model predicts
// grants and results, an echo FPU with variable latency closes the loop.
module tb_saph_fpu_arbiter;
    import saph_fpu_pkg::*;

    localparam int unsigned PORTS = 2;
    localparam int unsigned DEPTH = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PORTS-1:0]      req_trig;
    fpu_mode_t [PORTS-1:0] req_mode;
    float [PORTS-1:0]      req_lhs;
    float [PORTS-1:0]      req_rhs;
    logic [PORTS-1:0]      req_ready;
    logic [PORTS-1:0]      resp_valid;
    float                  resp_res;
    logic                  fpu_d_ready;
    fpu_modes_t            fpu_has_modes;
    logic                  fpu_d_trig;
    fpu_mode_t             fpu_d_mode;
    float                  fpu_d_lhs;
    float                  fpu_d_rhs;
    logic                  fpu_q_trig;
    float                  fpu_q_res;
    logic                  err_orphan;

    always #5 clk = ~clk;

    saph_fpu_arbiter #(.ports(PORTS), .depth(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_trig      (req_trig),
        .req_mode      (req_mode),
        .req_lhs       (req_lhs),
        .req_rhs       (req_rhs),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_res      (resp_res),
        .fpu_d_ready   (fpu_d_ready),
        .fpu_has_modes (fpu_has_modes),
        .fpu_d_trig    (fpu_d_trig),
        .fpu_d_mode    (fpu_d_mode),
        .fpu_d_lhs     (fpu_d_lhs),
        .fpu_d_rhs     (fpu_d_rhs),
        .fpu_q_trig    (fpu_q_trig),
        .fpu_q_res     (fpu_q_res),
        .err_orphan    (err_orphan)
    );

    typedef struct { int who; float res; } exp_t;
    typedef struct { float res; int unsigned due; } fpu_op_t;
    typedef struct { logic [PORTS-1:0] valid; float res; } obs_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    exp_t        sb_q[$];
    int          out_q[$];
    int          m_last;
    bit          m_orphan;
    fpu_op_t     fpu_pipe[$];
    int unsigned fpu_lat;
    int unsigned cyc;
    bit          inject_orphan;

    logic [PORTS-1:0] ready_log[$];
    bit               qtrig_log[$];
    obs_t             resp_log[$];
    int               dut_out;
    int               max_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration: lowest eligible index above the previous winner, else lowest overall.
    function automatic int pick(input bit pop_now);
        int elig[$];
        bit has_space;
        has_space = (out_q.size() < DEPTH) || pop_now;
        if (!fpu_d_ready || !has_space) return -1;
        for (int i = 0; i < PORTS; i++)
            if (req_trig[i] && fpu_has_modes[req_mode[i]]) elig.push_back(i);
        if (elig.size() == 0) return -1;
        foreach (elig[j])
            if (elig[j] > m_last) return elig[j];
        return elig[0];
    endfunction

    // One clock: present FPU result, check combinational outputs, advance model and FPU.
    task automatic cycle();
        int grant;
        bit pop_exp;
        bit orphan_now;
        bit from_pipe;
        from_pipe  = 1'b0;
        fpu_q_trig = 1'b0;
        fpu_q_res  = '0;
        if (fpu_pipe.size() > 0 && fpu_pipe[0].due <= cyc) begin
            fpu_q_trig = 1'b1;
            fpu_q_res  = fpu_pipe[0].res;
            from_pipe  = 1'b1;
        end else if (inject_orphan) begin
            fpu_q_trig = 1'b1;
            fpu_q_res  = $urandom;
        end
        #1;
        pop_exp    = !rst && fpu_q_trig && (out_q.size() > 0);
        orphan_now = !rst && fpu_q_trig && (out_q.size() == 0);
        grant      = rst ? -1 : pick(pop_exp);

        check("req_ready", req_ready, (grant >= 0) ? (64'd1 << grant) : 64'd0);
        check("fpu_d_trig", fpu_d_trig, (grant >= 0) ? 64'd1 : 64'd0);
        if (grant >= 0) begin
            check("fpu_d_mode", fpu_d_mode, req_mode[grant]);
            check("fpu_d_lhs", fpu_d_lhs, req_lhs[grant]);
            check("fpu_d_rhs", fpu_d_rhs, req_rhs[grant]);
        end else begin
            check("fpu_d_idle", {fpu_d_lhs, fpu_d_rhs}, 64'd0);
        end
        check("resp_present", |resp_valid, pop_exp);
        check("err_orphan", err_orphan, m_orphan);

        ready_log.push_back(req_ready);
        qtrig_log.push_back(fpu_q_trig);
        dut_out = rst ? 0 : dut_out + $countones(req_ready) - $countones(resp_valid);
        if (dut_out > max_out) max_out = dut_out;

        if (rst) begin
            out_q.delete();
            sb_q.delete();
            m_last   = PORTS - 1;
            m_orphan = 1'b0;
        end else begin
            if (pop_exp) void'(out_q.pop_front());
            if (orphan_now) m_orphan = 1'b1;
            if (grant >= 0) begin
                out_q.push_back(grant);
                sb_q.push_back('{who: grant, res: req_lhs[grant]});
                m_last = grant;
            end
        end

        if (from_pipe) void'(fpu_pipe.pop_front());
        if (fpu_d_trig) fpu_pipe.push_back('{res: fpu_d_lhs, due: cyc + fpu_lat});

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_trig      = '0;
        inject_orphan = 1'b0;
        while ((fpu_pipe.size() > 0 || sb_q.size() > 0) && n < 60) begin
            cycle();
            n++;
        end
        check("drain_done", fpu_pipe.size() + sb_q.size(), 0);
    endtask

    // Monitor: whenever the DUT presents a response, match it against the scoreboard head.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (resp_valid != '0) begin
            resp_log.push_back('{valid: resp_valid, res: resp_res});
            if (sb_q.size() == 0) begin
                check("resp_unexpected", resp_valid, 0);
            end else begin
                e = sb_q.pop_front();
                check("resp_valid", resp_valid, 64'd1 << e.who);
                check("resp_res", resp_res, e.res);
            end
        end else begin
            check("resp_res_idle", resp_res, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int r1;
        int third;
        int first_q;
        int n;

        rst           = 1'b1;
        req_trig      = '1;
        req_mode      = {FPU_MUL, FPU_ADD};
        req_lhs       = {32'h1111_1111, 32'h2222_2222};
        req_rhs       = {32'h3333_3333, 32'h4444_4444};
        fpu_d_ready   = 1'b1;
        fpu_has_modes = '1;
        fpu_q_trig    = 1'b0;
        fpu_q_res     = '0;
        inject_orphan = 1'b0;
        fpu_lat       = 1;
        m_last        = PORTS - 1;
        m_orphan      = 1'b0;
        cyc           = 0;
        dut_out       = 0;
        max_out       = 0;

        // Reset with requests pending: nothing may be granted.
        @(negedge clk);
        repeat (3) cycle();
        rst = 1'b0;

        // Both requesters continuously: 0,1,0,1.
        ready_log.delete();
        req_trig = 2'b11;
        repeat (4) cycle();
        check("rr_grant0", ready_log[0], 2'b01);
        check("rr_grant1", ready_log[1], 2'b10);
        check("rr_grant2", ready_log[2], 2'b01);
        check("rr_grant3", ready_log[3], 2'b10);
        drain();

        // Requester 0 asks for an unsupported mode; requester 1 must flow freely.
        fpu_has_modes          = '1;
        fpu_has_modes[FPU_DIV] = 1'b0;
        req_mode               = {FPU_ADD, FPU_DIV};
        req_trig               = 2'b11;
        ready_log.delete();
        repeat (8) cycle();
        r0 = 0;
        r1 = 0;
        foreach (ready_log[i]) begin
            r0 += int'(ready_log[i][0]);
            r1 += int'(ready_log[i][1]);
        end
        check("unsupported_never_granted", r0, 0);
        check("supported_granted_each_cycle", r1, 8);
        drain();

        // Depth 2, latency 3: third grant lands with the first returning result.
        fpu_has_modes = '1;
        req_mode      = {FPU_SUB, FPU_MUL};
        fpu_lat       = 3;
        req_trig      = 2'b11;
        ready_log.delete();
        qtrig_log.delete();
        dut_out = 0;
        max_out = 0;
        repeat (6) cycle();
        n = 0;
        third = -1;
        first_q = -1;
        foreach (ready_log[i]) begin
            if (ready_log[i] != '0) begin
                n++;
                if (n == 3 && third < 0) third = i;
            end
            if (qtrig_log[i] && first_q < 0) first_q = i;
        end
        check("third_grant_cycle", third, 3);
        check("first_result_cycle", first_q, 3);
        check("max_outstanding", max_out, 2);
        drain();

        // Issue order routing: requester 1 then requester 0.
        fpu_lat  = 2;
        resp_log.delete();
        req_trig = 2'b10;
        req_lhs  = {32'h3F80_0000, 32'hDEAD_BEEF};
        cycle();
        req_trig = 2'b01;
        req_lhs  = {32'h0BAD_F00D, 32'h4000_0000};
        cycle();
        drain();
        check("order_resp_count", resp_log.size(), 2);
        if (resp_log.size() >= 2) begin
            check("order_first_valid", resp_log[0].valid, 2'b10);
            check("order_first_res", resp_log[0].res, 32'h3F80_0000);
            check("order_second_valid", resp_log[1].valid, 2'b01);
            check("order_second_res", resp_log[1].res, 32'h4000_0000);
        end

        // Randomized traffic against the reference model.
        for (int t = 0; t < 400; t++) begin
            req_trig      = PORTS'($urandom);
            fpu_d_ready   = ($urandom_range(0, 3) != 0);
            fpu_has_modes = '1;
            if ($urandom_range(0, 2) == 0) fpu_has_modes[$urandom_range(0, 7)] = 1'b0;
            fpu_lat       = $urandom_range(1, 4);
            for (int i = 0; i < PORTS; i++) begin
                req_mode[i] = fpu_mode_t'($urandom_range(0, 7));
                req_lhs[i]  = $urandom;
                req_rhs[i]  = $urandom;
            end
            cycle();
        end
        fpu_d_ready = 1'b1;
        drain();

        // Result with nothing outstanding: dropped, sticky error flag.
        check("orphan_clear_before", err_orphan, 0);
        inject_orphan = 1'b1;
        cycle();
        inject_orphan = 1'b0;
        repeat (3) cycle();
        check("orphan_sticky", err_orphan, 1);

        // Reset with two operations in flight: tags dropped, requester 0 wins first.
        fpu_has_modes = '1;
        fpu_lat       = 6;
        req_trig      = 2'b11;
        repeat (2) cycle();
        check("two_outstanding", out_q.size(), 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_trig = '0;
        cycle();
        check("orphan_cleared_by_reset", err_orphan, 0);
        drain();
        cycle();
        check("late_results_orphaned", err_orphan, 1);
        fpu_lat  = 1;
        req_trig = 2'b11;
        ready_log.delete();
        cycle();
        check("first_grant_after_reset", ready_log[0], 2'b01);
        req_trig = '0;
        drain();
        check("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
